// File: rtl/pdec4_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdec4_seq: sequenced one-hot decoder for the PENC4 index.             |
// | Holds the select for HOLD cycles, idles GAP cycles, pulses done.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pdec4_seq #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] y,
  input  logic       valid,
  output logic       ready,
  output logic [3:0] a,
  output logic       busy,
  output logic       done
);

  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $fatal(1, "pdec4_seq: HOLD must be within 1..255");
  end
  if (GAP < 0 || GAP > 255) begin : g_bad_gap
    $fatal(1, "pdec4_seq: GAP must be within 0..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] c_hold_ld = 8'(HOLD - 1);
  localparam logic [7:0] c_gap_ld  = 8'(GAP - 1);
  localparam bit         c_has_gap = (GAP > 0);

  state_t     r_state, w_state_nx;
  logic [7:0] r_cnt,   w_cnt_nx;
  logic [1:0] r_idx,   w_idx_nx;
  logic [3:0] r_a,     w_a_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_idx   <= 2'd0;
      r_a     <= 4'b0000;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_a     <= w_a_nx;
    end
  end

  // The select is a flop of its own so it never glitches multi-hot on transitions.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_a_nx     = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (valid) begin
          w_state_nx = S_DRIVE;
          w_cnt_nx   = c_hold_ld;
          w_idx_nx   = y;
          w_a_nx     = 4'b0001 << y;
        end
      end
      S_DRIVE: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nx = r_cnt - 8'd1;
          w_a_nx   = 4'b0001 << r_idx;
        end else if (c_has_gap) begin
          w_state_nx = S_GAP;
          w_cnt_nx   = c_gap_ld;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nx = r_cnt - 8'd1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = 8'd0;
      end
    endcase
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DRIVE) && (r_cnt == 8'd0);
  assign a     = r_a;

endmodule
`default_nettype wire

// File: tb/tb_pdec4_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pdec4_seq: directed bench for pdec4_seq (default and HOLD=1/GAP=0) |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_pdec4_seq;

  localparam int H0 = 4;
  localparam int G0 = 1;
  localparam int H1 = 1;
  localparam int G1 = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] y0 = 2'd0, y1 = 2'd0;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic       ready0, busy0, done0, ready1, busy1, done1;
  logic [3:0] a0, a1;

  int total = 0;
  int bad   = 0;

  // Reference: t = cycles since accept (0 = idle); pulse occupies t=1..H.
  int t0 = 0, t1 = 0;
  logic [1:0] m_idx0 = 2'd0, m_idx1 = 2'd0;
  int acc0 = 0, acc1 = 0, dn0 = 0, dn1 = 0;

  pdec4_seq u0 (
    .clk(clk), .rst(rst), .y(y0), .valid(valid0),
    .ready(ready0), .a(a0), .busy(busy0), .done(done0)
  );

  pdec4_seq #(.HOLD(H1), .GAP(G1)) u1 (
    .clk(clk), .rst(rst), .y(y1), .valid(valid1),
    .ready(ready1), .a(a1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int n0, n1;
    logic [1:0] ni0, ni1;
    n0 = t0; n1 = t1; ni0 = m_idx0; ni1 = m_idx1;
    if (rst) n0 = 0;
    else if (t0 == 0) begin
      if (valid0) begin n0 = 1; ni0 = y0; acc0++; end
    end else n0 = (t0 == H0 + G0) ? 0 : t0 + 1;
    if (rst) n1 = 0;
    else if (t1 == 0) begin
      if (valid1) begin n1 = 1; ni1 = y1; acc1++; end
    end else n1 = (t1 == H1 + G1) ? 0 : t1 + 1;
    @(posedge clk);
    #1;
    t0 = n0; t1 = n1; m_idx0 = ni0; m_idx1 = ni1;
    if (done0 === 1'b1) dn0++;
    if (done1 === 1'b1) dn1++;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] ea0, ea1;
    ea0 = (t0 >= 1 && t0 <= H0) ? (4'b0001 << m_idx0) : 4'b0000;
    ea1 = (t1 >= 1 && t1 <= H1) ? (4'b0001 << m_idx1) : 4'b0000;
    chk({tag, ".a0"},     a0,              ea0);
    chk({tag, ".done0"},  {3'b0, done0},   {3'b0, t0 == H0});
    chk({tag, ".ready0"}, {3'b0, ready0},  {3'b0, t0 == 0});
    chk({tag, ".busy0"},  {3'b0, busy0},   {3'b0, t0 != 0});
    chk({tag, ".a1"},     a1,              ea1);
    chk({tag, ".done1"},  {3'b0, done1},   {3'b0, t1 == H1});
    chk({tag, ".ready1"}, {3'b0, ready1},  {3'b0, t1 == 0});
    chk({tag, ".oh0"},    {3'b0, $onehot0(a0)}, 4'd1);
    chk({tag, ".oh1"},    {3'b0, $onehot0(a1)}, 4'd1);
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    chk("rst.a0", a0, 4'b0000);
    chk("rst.ready0", {3'b0, ready0}, 4'd1);
    chk("rst.busy0", {3'b0, busy0}, 4'd0);
    chk("rst.done0", {3'b0, done0}, 4'd0);
    chk("rst.a1", a1, 4'b0000);
    rst = 1'b0;
    step(); check_model("idle");

    // Test 1: single accept of y=2
    valid0 = 1'b1; y0 = 2'd2;
    step(); valid0 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("t1.a", a0, 4'b0100);
      chk("t1.done", {3'b0, done0}, {3'b0, c == 4});
      chk("t1.ready", {3'b0, ready0}, 4'd0);
      step();
    end
    chk("t1.a5", a0, 4'b0000);
    chk("t1.ready5", {3'b0, ready0}, 4'd0);
    chk("t1.busy5", {3'b0, busy0}, 4'd1);
    step();
    chk("t1.ready6", {3'b0, ready0}, 4'd1);
    chk("t1.a6", a0, 4'b0000);

    // Test 2: valid held high, y=3 -> pulses at cycles 1, 7, 13
    valid0 = 1'b1; y0 = 2'd3;
    for (int c = 1; c <= 18; c++) begin
      step();
      chk("t2.a", a0, ((c % 6) >= 1 && (c % 6) <= 4) ? 4'b1000 : 4'b0000);
      chk("t2.ready", {3'b0, ready0}, {3'b0, (c % 6) == 0});
      check_model("t2");
    end
    valid0 = 1'b0;
    step(); check_model("t2.end");

    // Test 3: y changes mid-pulse; pulse keeps its latched index
    valid0 = 1'b1; y0 = 2'd1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) y0 = 2'd0;
      if (c <= 4) chk("t3.hold", a0, 4'b0010);
      if (c == 5 || c == 6) chk("t3.idle", a0, 4'b0000);
      if (c == 7) chk("t3.next", a0, 4'b0001);
      check_model("t3");
    end
    valid0 = 1'b0;

    // Test 4: async reset mid-drive clears outputs before any edge
    for (int c = 0; c < 6; c++) step();
    valid0 = 1'b1; y0 = 2'd2;
    step(); valid0 = 1'b0;
    step();
    chk("t4.pre", a0, 4'b0100);
    #2 rst = 1'b1;
    #1;
    chk("t4.a", a0, 4'b0000);
    chk("t4.busy", {3'b0, busy0}, 4'd0);
    chk("t4.ready", {3'b0, ready0}, 4'd1);
    chk("t4.done", {3'b0, done0}, 4'd0);
    t0 = 0; t1 = 0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t4.quiet", a0, 4'b0000);
      check_model("t4");
    end

    // Test 5: HOLD=1 GAP=0 sweep, 2-cycle spacing, done with each pulse
    valid1 = 1'b1; y1 = 2'd0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t5.a", a1, 4'(1 << k));
      chk("t5.done", {3'b0, done1}, 4'd1);
      chk("t5.busy", {3'b0, busy1}, 4'd1);
      if (k < 3) y1 = 2'(k + 1);
      else valid1 = 1'b0;
      step();
      chk("t5.gap", a1, 4'b0000);
      chk("t5.gdone", {3'b0, done1}, 4'd0);
      chk("t5.ready", {3'b0, ready1}, 4'd1);
      check_model("t5");
      step();
    end

    // Test 6: random traffic on both instances against the model
    for (int c = 0; c < 8; c++) step();
    acc0 = 0; acc1 = 0; dn0 = 0; dn1 = 0;
    for (int c = 0; c < 400; c++) begin
      valid0 = ($urandom_range(0, 2) == 0);
      valid1 = ($urandom_range(0, 2) == 0);
      y0 = 2'($urandom_range(0, 3));
      y1 = 2'($urandom_range(0, 3));
      step();
      check_model("t6");
    end
    valid0 = 1'b0; valid1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check_model("t6.drain");
    end
    total++;
    assert (dn0 == acc0 && dn1 == acc1 && acc0 > 0 && acc1 > 0) else begin
      bad++;
      $error("FAIL t6.count done0=%0d acc0=%0d done1=%0d acc1=%0d", dn0, acc0, dn1, acc1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pdec4_seq.md
Name: pdec4_seq

Overview:
- Counterpart to the 4-bit priority encoder PENC4: consumes its 2-bit index Y and VALID flag and regenerates a one-hot 4-bit select A.
- Drives A for a programmable number of cycles, inserts an optional idle gap, then signals completion.
- Sits downstream of PENC4 and drives one-hot enables (e.g. grant or strobe lines) that need a guaranteed minimum pulse width and spacing.

Parameters:
HOLD, 4, cycles A is held one-hot per accepted index; legal range 1..255
GAP, 1, forced idle cycles after each pulse, A=0 and READY=0; legal range 0..255

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
Y  input  2  encoded index, same encoding as PENC4 Y output
VALID  input  1  Y is meaningful; request to decode
READY  output  1  block can accept a new index this cycle
A  output  4  one-hot decoded select, A[Y]=1 while driving, else 0000
BUSY  output  1  high in DRIVE or GAP state
DONE  output  1  single-cycle pulse on the last cycle of a DRIVE period

Behaviour:
- Reset: one clock (CLK); reset (RST) is asynchronous and active-high. While RST=1: state=IDLE, A=0000, DONE=0, BUSY=0, READY=1, counter=0, latched index=0. A clears immediately on RST assertion, without waiting for a clock edge, including mid-DRIVE.
- States: IDLE, DRIVE, GAP. Registered state; 8-bit down-counter; 2-bit latched index.
- READY = (state==IDLE). BUSY = (state!=IDLE). Both are decoded from registered state only; no combinational path from VALID or Y.
- IDLE: on a rising edge with VALID=1 and READY=1, latch Y, load counter=HOLD-1 and go to DRIVE. Otherwise remain in IDLE.
- DRIVE: A = 1 << latched index, and is registered (not combinational from Y).
  - If counter!=0: decrement.
  - If counter==0: DONE=1 this cycle. Next state is GAP with counter=GAP-1 if GAP>0, else IDLE.
- GAP: A=0000. Decrement until counter==0, then go to IDLE.
- Latency: VALID accepted at edge k -> A one-hot for cycles k+1 .. k+HOLD, DONE high in cycle k+HOLD, A=0000 from cycle k+HOLD+1.
  - GAP cycles follow, then 1 IDLE cycle with READY=1.
  - With VALID held high, accepts are spaced exactly HOLD+GAP+1 cycles apart.
- VALID while READY=0 is ignored: no queueing and no error flag. Upstream must hold VALID until it sees READY.
- Changes on Y after acceptance have no effect on A for the current pulse.
- A is either 0000 or exactly one bit set. It is never multi-hot, including across state transitions.
- HOLD=1: A is high for one cycle and DONE is high in that same cycle.
- GAP=0: DRIVE goes directly to IDLE.
- Counter arithmetic is 8-bit unsigned with no wrap: it is loaded only with values ≤254 and never decremented below 0.
- Elaboration-time check: HOLD outside 1..255 or GAP outside 0..255 is a fatal error.

Test Plan:
1. Default params. Release RST, then VALID=1, Y=2 for one cycle at edge 0 -> A=0100 in cycles 1-4; DONE=1 only in cycle 4; A=0000 and READY=0 in cycle 5; READY=1 in cycle 6.
2. Default params, VALID held high with Y=3 -> A=1000 pulses starting cycles 1, 7, 13 (spacing 6); READY low in cycles 1-5 and 7-11.
3. Y changed to 0 during cycles 2-3 of an accepted Y=1 pulse, VALID high -> A stays 0010 for the full 4 cycles; next pulse (cycle 7) is A=0001.
4. RST asserted asynchronously mid-cycle in cycle 2 of a DRIVE -> A=0000, BUSY=0, READY=1, DONE=0 immediately, before the next edge. No residual pulse after release until a new VALID.
5. HOLD=1, GAP=0, VALID held high, Y sweeps 0,1,2,3 -> A=0001, 0010, 0100, 1000 each for 1 cycle, 2-cycle spacing, DONE coincident with each.
6. Sweep all Y values with random VALID gaps, checked against a reference model -> A is always 0000 or one-hot with A[latched index]=1, and the count of DONE pulses equals the number of accepts.
